// File: rtl/axi_types_pkg.sv
// Shared AXI4 encodings and write-engine state type.
package axi_types_pkg;

  localparam int unsigned AxiIdHeaderSize      = 4;
  localparam int unsigned AxiTransactionIdSize = 4;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    WrIdle = 2'd0,
    WrData = 2'd1,
    WrResp = 2'd2
  } wr_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_calc.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by the read and write engines.
module axi_burst_addr_calc
  import axi_types_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  logic [2:0]    size_i,
  input  logic [7:0]    len_i,
  input  logic [1:0]    burst_i,
  output logic [AW-1:0] next_addr_o
);

  logic [AW-1:0] step;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr;
  logic [AW-1:0] total;
  logic [AW-1:0] wrap_base;

  always_comb begin
    step      = AW'(1) << size_i;
    aligned   = addr_i & ~(step - AW'(1));
    incr      = aligned + step;
    total     = step * (AW'(len_i) + AW'(1));
    wrap_base = addr_i & ~(total - AW'(1));
    unique case (burst_i)
      BurstIncr: next_addr_o = incr;
      BurstWrap: next_addr_o = (incr == wrap_base + total) ? wrap_base : incr;
      default:   next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_wr_beat_engine.sv
// Single-outstanding AXI4 write burst engine: AW capture, per-beat addressing, memory port, B response.
module axi_wr_beat_engine
  import axi_types_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned IDW = AxiIdHeaderSize + AxiTransactionIdSize
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [IDW-1:0]    awid,
  input  logic [AW-1:0]     awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [IDW-1:0]    bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb,
  input  logic              mem_ready
);

  localparam logic [1:0]  StIdle  = WrIdle;
  localparam logic [1:0]  StData  = WrData;
  localparam logic [1:0]  StResp  = WrResp;
  localparam int unsigned SizeMax = $clog2(DW / 8);

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [2:0]     size_q, size_d;
  logic [1:0]     burst_q, burst_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           last_err_q, last_err_d;

  logic [AW-1:0]  next_addr;
  logic [AW-1:0]  aw_step;
  logic [AW-1:0]  aw_aligned;
  logic [16:0]    aw_end_off;
  logic           aw_illegal;
  logic           beat_done;
  logic           last_beat;

  axi_burst_addr_calc #(
    .AW (AW)
  ) u_addr_calc (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Legality of the AW request; the 4 KB test uses the burst's end offset within its page.
  always_comb begin
    aw_step    = AW'(1) << awsize;
    aw_aligned = awaddr & ~(aw_step - AW'(1));
    aw_end_off = 17'(aw_aligned[11:0]) + ((17'(awlen) + 17'd1) << awsize);
    aw_illegal = 1'b0;
    if (awburst == BurstRsvd) aw_illegal = 1'b1;
    if (32'(awsize) > SizeMax) aw_illegal = 1'b1;
    if (awburst == BurstWrap && !wrap_len_ok(awlen)) aw_illegal = 1'b1;
    if (awburst == BurstWrap && (awaddr & (aw_step - AW'(1))) != '0) aw_illegal = 1'b1;
    if (awburst == BurstIncr && aw_end_off > 17'd4096) aw_illegal = 1'b1;
  end

  // Illegal bursts still drain W beats so the master is never deadlocked.
  always_comb begin
    awready   = !areset && (state_q == StIdle);
    wready    = !areset && (state_q == StData) && (err_q || mem_ready);
    bvalid    = !areset && (state_q == StResp);
    mem_we    = wvalid && wready && !err_q;
    mem_addr  = areset ? '0 : addr_q;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    bid       = areset ? '0 : id_q;
    bresp     = areset ? RespOkay : ((err_q || last_err_q) ? RespSlverr : RespOkay);
    beat_done = wvalid && wready;
    last_beat = (cnt_q == len_q);
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    last_err_d = last_err_q;
    unique case (state_q)
      StIdle: begin
        if (awvalid) begin
          id_d       = awid;
          addr_d     = awaddr;
          len_d      = awlen;
          size_d     = awsize;
          burst_d    = awburst;
          cnt_d      = 8'd0;
          err_d      = aw_illegal;
          last_err_d = 1'b0;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat_done) begin
          cnt_d  = cnt_q + 8'd1;
          addr_d = next_addr;
          // A wlast mismatch only taints the response; beats keep reaching memory.
          if (wlast != last_beat) last_err_d = 1'b1;
          if (last_beat) state_d = StResp;
        end
      end
      StResp: begin
        if (bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= BurstFixed;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      last_err_q <= last_err_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_beat_engine.sv
// Directed and randomized bursts for axi_wr_beat_engine against a per-beat arithmetic model.
module tb_axi_wr_beat_engine;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IDW = 8;

  logic            aclk = 1'b0;
  logic            areset;
  logic [IDW-1:0]  awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_ready;

  int nchk = 0;
  int nerr = 0;

  always #5 aclk = ~aclk;

  axi_wr_beat_engine #(
    .DW  (DW),
    .AW  (AW),
    .IDW (IDW)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bid       (bid),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i, straight from the burst definitions.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    longint step  = longint'(1) << size;
    longint total = step * (len + 1);
    longint al    = (longint'(a) / step) * step;
    longint base  = (longint'(a) / total) * total;
    if (burst == 1) return (i == 0) ? a : 32'(al + i * step);
    if (burst == 2) return 32'(base + ((longint'(a) - base + i * step) % total));
    return a;
  endfunction

  function automatic bit exp_illegal(input logic [31:0] a, input int len, input int size,
                                     input int burst);
    longint step = longint'(1) << size;
    longint al   = (longint'(a) / step) * step;
    if (burst == 3) return 1'b1;
    if (size > 2) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (burst == 2 && (longint'(a) % step) != 0) return 1'b1;
    if (burst == 1 && (longint'(a) >> 12) != ((al + (len + 1) * step - 1) >> 12)) return 1'b1;
    return 1'b0;
  endfunction

  // Starts and ends just after a rising edge.
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int bad_beat,
                           input int stall_beat, input int stall_len, input bit rand_stall,
                           input int abort_after);
    bit ill;
    bit werr = 1'b0;
    bit mr;
    bit wv;
    bit wl;
    int beat = 0;
    int cyc = 0;
    int stalled = 0;
    int nwe = 0;
    int hold;
    ill = exp_illegal(addr, len, size, burst);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    wvalid = 1'b1; wlast = 1'b0;
    @(negedge aclk);
    chk("aw_awready", awready, 1);
    chk("aw_wready_stalled", wready, 0);
    @(posedge aclk); #1;
    awvalid = 1'b0; awaddr = $urandom; awid = 8'($urandom);
    while (beat <= len && cyc < 2000) begin
      wv = rand_stall ? ($urandom_range(4) != 0) : 1'b1;
      mr = 1'b1;
      if (beat == stall_beat && stalled < stall_len) begin
        mr = 1'b0;
        stalled++;
      end else if (rand_stall && $urandom_range(3) == 0) begin
        mr = 1'b0;
      end
      wl = (bad_beat >= 0) ? (beat == bad_beat) : (beat == len);
      wvalid = wv; mem_ready = mr; wlast = wl;
      wdata = $urandom; wstrb = 4'($urandom);
      @(negedge aclk);
      chk("w_wready", wready, ill ? 1'b1 : mr);
      chk("w_mem_we", mem_we, wv && mr && !ill);
      if (!ill) chk("w_mem_addr", mem_addr, beat_addr(addr, len, size, burst, beat));
      if (mem_we) begin
        chk("w_mem_wdata", mem_wdata, wdata);
        nwe++;
      end
      @(posedge aclk); #1;
      cyc++;
      if (wv && (ill || mr)) begin
        if (wl != (beat == len)) werr = 1'b1;
        beat++;
        if (abort_after >= 0 && beat == abort_after) begin
          areset = 1'b1; wvalid = 1'b1; mem_ready = 1'b1;
          @(negedge aclk);
          chk("rst_awready", awready, 0);
          chk("rst_wready", wready, 0);
          chk("rst_bvalid", bvalid, 0);
          chk("rst_mem_we", mem_we, 0);
          chk("rst_bid", bid, 0);
          chk("rst_bresp", bresp, 0);
          chk("rst_mem_addr", mem_addr, 0);
          @(posedge aclk); #1;
          areset = 1'b0; wvalid = 1'b0;
          @(negedge aclk);
          chk("rst_awready_after", awready, 1);
          chk("rst_bvalid_after", bvalid, 0);
          @(posedge aclk); #1;
          return;
        end
      end
    end
    wvalid = 1'b0; wlast = 1'b0; mem_ready = 1'b1;
    chk("w_beats_done", beat, len + 1);
    @(negedge aclk);
    chk("b_bvalid", bvalid, 1);
    chk("b_bid", bid, id);
    chk("b_bresp", bresp, (ill || werr) ? 2'b10 : 2'b00);
    chk("b_awready", awready, 0);
    hold = rand_stall ? $urandom_range(3) : 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("b_hold_bvalid", bvalid, 1);
      chk("b_hold_bresp", bresp, (ill || werr) ? 2'b10 : 2'b00);
    end
    @(posedge aclk); #1;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    chk("b_done_awready", awready, 1);
    chk("b_done_bvalid", bvalid, 0);
    chk("mem_we_count", nwe, ill ? 0 : len + 1);
    @(posedge aclk); #1;
  endtask

  initial begin
    int len;
    int size;
    int burst;
    logic [31:0] addr;
    areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; mem_ready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("reset_awready", awready, 0);
    chk("reset_bvalid", bvalid, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    @(posedge aclk); #1;
    areset = 1'b0;

    run_burst(8'h11, 32'h1004, 3, 2, 1, -1, -1, 0, 1'b0, -1);
    run_burst(8'h22, 32'h0038, 3, 2, 2, -1, -1, 0, 1'b0, -1);
    run_burst(8'h33, 32'h0200, 2, 2, 0, -1, 1, 3, 1'b0, -1);
    run_burst(8'h44, 32'h0300, 1, 2, 3, -1, -1, 0, 1'b0, -1);
    run_burst(8'h55, 32'h0400, 3, 2, 1, 1, -1, 0, 1'b0, -1);
    run_burst(8'h66, 32'h0FFC, 1, 2, 1, -1, -1, 0, 1'b0, -1);
    run_burst(8'h77, 32'h2000, 3, 2, 1, -1, -1, 0, 1'b0, 2);
    run_burst(8'h88, 32'h3000, 3, 2, 1, -1, -1, 0, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      burst = ($urandom_range(9) == 0) ? 3 : $urandom_range(2);
      size  = ($urandom_range(7) == 0) ? 3 : $urandom_range(2);
      if (burst == 2 && $urandom_range(4) != 0) len = (2 << $urandom_range(3)) - 1;
      else len = $urandom_range(15);
      addr = $urandom;
      if ($urandom_range(3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      run_burst(8'($urandom), addr, len, size, burst,
                ($urandom_range(9) == 0) ? int'($urandom_range(len)) : -1,
                -1, 0, 1'b1, -1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
